// File: rtl/arbitro_pkg.sv
// Shared definitions for the weighted round-robin class arbiter:
// word field positions, FSM state encoding and default class weights.
package arbitro_pkg;

   localparam int NUM_CLASSES = 4;

   // Word layout: [11:10] class, [9:8] destination, [7:0] data
   localparam int CLASS_MSB = 11;
   localparam int CLASS_LSB = 10;
   localparam int DEST_MSB  = 9;
   localparam int DEST_LSB  = 8;

   // Default weights: maximum consecutive words granted per class
   localparam int DEF_WEIGHT0 = 4;
   localparam int DEF_WEIGHT1 = 2;
   localparam int DEF_WEIGHT2 = 1;
   localparam int DEF_WEIGHT3 = 1;

   // ARB takes a decision, HOLD is the mandatory idle cycle after a transfer
   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/wrr_select.sv
// Combinational class selection: eligibility per class and the winner
// of the weighted round-robin scan starting at the pointer class.
module wrr_select
   import arbitro_pkg::*;
(
   input  logic [1:0] ptr,
   input  logic [3:0] credit,
   input  logic [3:0] fifos_empty,
   input  logic [3:0] dest_almost_full,
   input  logic [7:0] dest_fields,
   output logic [3:0] eligible,
   output logic [1:0] sel,
   output logic       found
);

   logic [1:0] cand;

   // Pointer class wins while it has credit; otherwise first eligible after it
   always_comb begin
      eligible = '0;
      sel      = ptr;
      found    = 1'b0;
      cand     = ptr;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         eligible[c] = !fifos_empty[c] && !dest_almost_full[dest_fields[c*2 +: 2]];
      end
      if (eligible[ptr] && (credit != 4'd0)) begin
         sel   = ptr;
         found = 1'b1;
      end else begin
         for (int k = 1; k < NUM_CLASSES; k++) begin
            cand = ptr + 2'(k);
            if (!found && eligible[cand]) begin
               sel   = cand;
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/arbitro_wrr.sv
// Weighted round-robin arbiter moving words from four class FIFOs to four
// destination FIFOs. One word per ARB decision, followed by one HOLD cycle.
// Handshake: pop[c] and push[d] are one-cycle coincident pulses; data_out is
// valid exactly while push is nonzero and the FIFOs act on that edge.
module arbitro_wrr
   import arbitro_pkg::*;
#(
   parameter int WORD_SIZE = 12,
   parameter int WEIGHT0   = DEF_WEIGHT0,
   parameter int WEIGHT1   = DEF_WEIGHT1,
   parameter int WEIGHT2   = DEF_WEIGHT2,
   parameter int WEIGHT3   = DEF_WEIGHT3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4*WORD_SIZE-1:0] data_in,
   input  logic [3:0]             fifos_empty,
   input  logic [3:0]             dest_almost_full,
   output logic [3:0]             pop,
   output logic [3:0]             push,
   output logic [WORD_SIZE-1:0]   data_out,
   output logic [1:0]             grant,
   output logic [4:0]             cuenta,
   output logic                   state_dbg
);

   function automatic logic [3:0] weight_of(input logic [1:0] c);
      case (c)
         2'd0:    weight_of = 4'(WEIGHT0);
         2'd1:    weight_of = 4'(WEIGHT1);
         2'd2:    weight_of = 4'(WEIGHT2);
         default: weight_of = 4'(WEIGHT3);
      endcase
   endfunction

   state_t               state_q, state_d;
   logic [1:0]           ptr_q, ptr_d;
   logic [3:0]           credit_q, credit_d;
   logic [3:0]           pop_q, pop_d;
   logic [3:0]           push_q, push_d;
   logic [WORD_SIZE-1:0] data_out_q, data_out_d;
   logic [1:0]           grant_q, grant_d;
   logic [4:0]           cuenta_q, cuenta_d;

   logic [7:0]           dest_fields;
   logic [3:0]           eligible;
   logic [1:0]           sel;
   logic                 found;
   logic [WORD_SIZE-1:0] sel_word;
   logic [1:0]           sel_dest;
   logic [3:0]           cred_after;

   // Destination field of every class head word
   always_comb begin
      dest_fields = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         dest_fields[c*2 +: 2] = data_in[c*WORD_SIZE + DEST_LSB +: 2];
      end
   end

   wrr_select u_select (
      .ptr              (ptr_q),
      .credit           (credit_q),
      .fifos_empty      (fifos_empty),
      .dest_almost_full (dest_almost_full),
      .dest_fields      (dest_fields),
      .eligible         (eligible),
      .sel              (sel),
      .found            (found)
   );

   // Head word of the selected class and its destination
   always_comb begin
      sel_word = data_in[sel*WORD_SIZE +: WORD_SIZE];
      sel_dest = sel_word[DEST_MSB:DEST_LSB];
   end

   // Next-state: issue a transfer in ARB, rest one cycle in HOLD
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      credit_d   = credit_q;
      pop_d      = 4'b0000;
      push_d     = 4'b0000;
      data_out_d = data_out_q;
      grant_d    = grant_q;
      cuenta_d   = cuenta_q;
      cred_after = 4'd0;
      case (state_q)
         ST_ARB: begin
            if (found) begin
               pop_d      = 4'b0001 << sel;
               push_d     = 4'b0001 << sel_dest;
               data_out_d = sel_word;
               grant_d    = sel;
               cuenta_d   = cuenta_q + 5'd1;
               state_d    = ST_HOLD;
               // A class other than the pointer takes over with a fresh budget
               if (sel == ptr_q) cred_after = credit_q - 4'd1;
               else              cred_after = weight_of(sel) - 4'd1;
               if (cred_after == 4'd0) begin
                  ptr_d    = sel + 2'd1;
                  credit_d = weight_of(sel + 2'd1);
               end else begin
                  ptr_d    = sel;
                  credit_d = cred_after;
               end
            end
         end
         ST_HOLD: state_d = ST_ARB;
         default: state_d = ST_ARB;
      endcase
   end

   // State and registered outputs; reset cancels any in-flight pulse at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ARB;
         ptr_q      <= 2'd0;
         credit_q   <= 4'(WEIGHT0);
         pop_q      <= 4'b0000;
         push_q     <= 4'b0000;
         data_out_q <= '0;
         grant_q    <= 2'd0;
         cuenta_q   <= 5'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         pop_q      <= pop_d;
         push_q     <= push_d;
         data_out_q <= data_out_d;
         grant_q    <= grant_d;
         cuenta_q   <= cuenta_d;
      end
   end

   assign pop       = pop_q;
   assign push      = push_q;
   assign data_out  = data_out_q;
   assign grant     = grant_q;
   assign cuenta    = cuenta_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_arbitro_wrr.sv
// Bench for arbitro_wrr: class FIFOs are modelled as queues, a reference
// WRR model predicts every decision, and a scoreboard checks forwarded words.
module tb_arbitro_wrr;

   localparam int W = 12;

   logic           clk;
   logic           reset;
   logic [4*W-1:0] data_in;
   logic [3:0]     fifos_empty;
   logic [3:0]     dest_almost_full;
   logic [3:0]     pop;
   logic [3:0]     push;
   logic [W-1:0]   data_out;
   logic [1:0]     grant;
   logic [4:0]     cuenta;
   logic           state_dbg;

   arbitro_wrr dut (
      .clk              (clk),
      .reset            (reset),
      .data_in          (data_in),
      .fifos_empty      (fifos_empty),
      .dest_almost_full (dest_almost_full),
      .pop              (pop),
      .push             (push),
      .data_out         (data_out),
      .grant            (grant),
      .cuenta           (cuenta),
      .state_dbg        (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Class FIFOs seen by the DUT, and the scoreboard of expected {grant, word}
   logic [W-1:0]  cls_q [4][$];
   logic [13:0]   exp_q[$];

   // Reference model state
   int m_ptr, m_credit, m_cuenta;
   bit m_hold;
   int weight [4] = '{4, 2, 1, 1};

   function automatic logic [W-1:0] mk(input int cls, input int dst, input int dat);
      logic [1:0] c2, d2;
      logic [7:0] v8;
      c2 = 2'(cls);
      d2 = 2'(dst);
      v8 = 8'(dat);
      return {c2, d2, v8};
   endfunction

   task automatic load(input int cls, input int n, input int dst);
      for (int i = 0; i < n; i++) begin
         int d;
         d = (dst < 0) ? int'($urandom_range(0, 3)) : dst;
         cls_q[cls].push_back(mk(cls, d, $urandom_range(0, 255)));
      end
   endtask

   task automatic update_inputs();
      for (int c = 0; c < 4; c++) begin
         fifos_empty[c] = (cls_q[c].size() == 0);
         data_in[c*W +: W] = (cls_q[c].size() != 0) ? cls_q[c][0] : '0;
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && push != 4'b0000) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_push", {28'd0, push}, 32'd0);
         end else begin
            logic [13:0] e;
            e = exp_q.pop_front();
            check("sb_data", {20'd0, data_out}, {20'd0, e[11:0]});
            check("sb_grant", {30'd0, grant}, {30'd0, e[13:12]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic reset_dut();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) cls_q[c].delete();
      exp_q.delete();
      dest_almost_full = 4'b0000;
      update_inputs();
      m_ptr = 0; m_credit = weight[0]; m_cuenta = 0; m_hold = 0;
      @(posedge clk); #1;
      check("rst_pop", {28'd0, pop}, 32'd0);
      check("rst_push", {28'd0, push}, 32'd0);
      check("rst_data", {20'd0, data_out}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_cuenta", {27'd0, cuenta}, 32'd0);
      check("rst_state", {31'd0, state_dbg}, 32'd0);
      reset = 1'b0;
   endtask

   // One clock: predict from the applied inputs, advance, compare
   task automatic step(output bit did, output int gsel);
      logic [3:0] e_pop, e_push;
      logic [3:0] elig;
      logic [W-1:0] hw;
      logic [1:0] hd;
      int sel;
      bit found;
      update_inputs();
      e_pop = 0; e_push = 0; found = 0; sel = 0;
      if (m_hold) begin
         m_hold = 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            hw = data_in[c*W +: W];
            hd = hw[9:8];
            elig[c] = !fifos_empty[c] && !dest_almost_full[hd];
         end
         if (elig[m_ptr] && m_credit > 0) begin
            sel = m_ptr; found = 1;
         end else begin
            for (int k = 1; k < 4; k++) begin
               if (!found && elig[(m_ptr + k) % 4]) begin
                  sel = (m_ptr + k) % 4; found = 1;
               end
            end
         end
         if (found) begin
            hw = cls_q[sel][0];
            hd = hw[9:8];
            e_pop  = 4'b0001 << sel;
            e_push = 4'b0001 << hd;
            exp_q.push_back({2'(sel), hw});
            m_cuenta = (m_cuenta + 1) % 32;
            if (sel == m_ptr) m_credit = m_credit - 1;
            else begin m_ptr = sel; m_credit = weight[sel] - 1; end
            if (m_credit == 0) begin
               m_ptr = (m_ptr + 1) % 4;
               m_credit = weight[m_ptr];
            end
            m_hold = 1;
         end
      end
      @(posedge clk); #1;
      check("pop", {28'd0, pop}, {28'd0, e_pop});
      check("push", {28'd0, push}, {28'd0, e_push});
      check("cuenta", {27'd0, cuenta}, 32'(m_cuenta));
      check("state", {31'd0, state_dbg}, {31'd0, m_hold});
      if (found) void'(cls_q[sel].pop_front());
      did = found;
      gsel = sel;
   endtask

   // Run until n transfers; optionally compare DUT grant against a table
   task automatic run_xfers(input int n, input bit use_tab, input int tab [8], input int tab_len);
      int done, budget, g;
      bit d;
      done = 0; budget = 0;
      while (done < n && budget < 4 * n + 20) begin
         step(d, g);
         if (d) begin
            if (use_tab) check("grant_seq", {30'd0, grant}, 32'(tab[done % tab_len]));
            done++;
         end
         budget++;
      end
      check("xfer_budget", 32'(done), 32'(n));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int seq_full [8] = '{0, 0, 0, 0, 1, 1, 2, 3};
      int seq_idle [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      int seq_af   [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
      int none     [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
      bit d;
      int g;

      reset = 1'b1;
      data_in = '0;
      fifos_empty = 4'b1111;
      dest_almost_full = 4'b0000;

      // Single word on class 2
      reset_dut();
      cls_q[2].push_back(12'hA5C);
      step(d, g);
      check("t1_pop", {28'd0, pop}, 32'h4);
      check("t1_push", {28'd0, push}, 32'h4);
      check("t1_data", {20'd0, data_out}, 32'hA5C);
      check("t1_grant", {30'd0, grant}, 32'd2);
      check("t1_cuenta", {27'd0, cuenta}, 32'd1);
      step(d, g);
      check("t1_hold_pop", {28'd0, pop}, 32'd0);
      step(d, g);

      // All classes busy, default weights
      reset_dut();
      for (int c = 0; c < 4; c++) load(c, 8, -1);
      run_xfers(16, 1'b1, seq_full, 8);
      check("t2_cuenta", {27'd0, cuenta}, 32'd16);

      // Class 0 blocked by almost-full on destination 1
      reset_dut();
      cls_q[0].push_back(mk(0, 1, 8'h11));
      load(1, 3, 3);
      dest_almost_full = 4'b0010;
      run_xfers(3, 1'b1, seq_af, 8);
      dest_almost_full = 4'b0000;
      run_xfers(1, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1);

      // Idle then restart at pointer class 0 with full credit
      reset_dut();
      for (int i = 0; i < 10; i++) step(d, g);
      check("t4_idle_cuenta", {27'd0, cuenta}, 32'd0);
      load(0, 5, -1);
      load(1, 1, -1);
      run_xfers(6, 1'b1, seq_idle, 8);

      // Counter wrap after 33 transfers
      reset_dut();
      load(0, 20, -1); load(1, 10, -1); load(2, 6, -1); load(3, 6, -1);
      run_xfers(33, 1'b0, none, 8);
      check("t5_wrap", {27'd0, cuenta}, 32'd1);

      // Randomised traffic with almost-full changing every cycle
      reset_dut();
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            int c;
            c = $urandom_range(0, 3);
            if (cls_q[c].size() < 6) load(c, 1, -1);
         end
         dest_almost_full = 4'($urandom_range(0, 15));
         step(d, g);
      end
      dest_almost_full = 4'b0000;
      for (int i = 0; i < 80; i++) step(d, g);

      // Asynchronous reset while push is high
      reset_dut();
      load(0, 2, 0);
      step(d, g);
      check("t6_push_pre", {28'd0, push}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("t6_push_async", {28'd0, push}, 32'd0);
      check("t6_pop_async", {28'd0, pop}, 32'd0);
      check("t6_data_async", {20'd0, data_out}, 32'd0);
      check("t6_cuenta_async", {27'd0, cuenta}, 32'd0);
      reset_dut();
      load(1, 1, -1);
      load(0, 1, -1);
      step(d, g);
      check("t6_first_grant", {30'd0, grant}, 32'd0);
      step(d, g);
      step(d, g);
      step(d, g);

      @(posedge clk); #1;
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
